set_count_reader: RTL and testbench

- Consumer end of the 8x8 coverage-table interface. Two upstream writers each fill one 64-entry, 1-bit table (A and B) with "point inside circle" flags.
- This block reads both tables in a single 64-address pass and combines the two bits per address with a set operation.
- It counts the matching points and presents the count with a one-cycle valid pulse to the top-level controller.

---
 rtl/set_count_reader.sv | 117 +++++++++++
 tb/tb_set_count_reader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/set_count_reader.sv
// Reads coverage tables A and B in one 64-address pass, combines bits by set op, counts hits.
// Optional macro SET_CNT_CLEAR_EN adds clr_we/clr_addr so writers can zero tables during the pass.
module set_count_reader #(
  parameter int ADDR_W = 6,
  parameter int CNT_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              a_data,
  input  logic              b_data,
  output logic              busy,
  output logic [CNT_W-1:0]  count,
  output logic              valid
`ifdef SET_CNT_CLEAR_EN
  ,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        mode_q;
  logic              pipe_v;
  logic [CNT_W-1:0]  count_q;
  logic              accept;
  logic              hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = READ;
        end
      end
      READ:    if (addr_q == LAST_ADDR) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    hit = 1'b0;
    case (mode_q)
      2'b00:   hit = a_data;
      2'b01:   hit = a_data & b_data;
      2'b10:   hit = a_data | b_data;
      default: hit = a_data ^ b_data;
    endcase
  end

  // Address counter parks on the last entry instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      mode_q <= 2'b00;
    end else if (accept) begin
      addr_q <= '0;
      mode_q <= mode;
    end else if (state == READ && addr_q != LAST_ADDR) begin
      addr_q <= addr_q + 1'b1;
    end
  end

  // Tables have one cycle of read latency, so pipe_v marks cycles carrying returned data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_v  <= 1'b0;
      count_q <= '0;
    end else begin
      pipe_v <= rd_en;
      if (accept)      count_q <= '0;
      else if (pipe_v) count_q <= count_q + CNT_W'(hit);
    end
  end

  assign rd_en   = (state == READ);
  assign rd_addr = addr_q;
  assign busy    = (state != IDLE);
  assign valid   = (state == DONE);
  assign count   = count_q;

`ifdef SET_CNT_CLEAR_EN
  logic [ADDR_W-1:0] clr_addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        clr_addr_q <= '0;
    else if (rd_en) clr_addr_q <= rd_addr;
  end

  assign clr_we   = pipe_v;
  assign clr_addr = clr_addr_q;
`endif

endmodule

// File: tb/tb_set_count_reader.sv
// Bench for set_count_reader: table memory model, pass-level reference model, directed passes.
module tb_set_count_reader;
  localparam int ADDR_W = 6;
  localparam int CNT_W  = 7;
  localparam int N      = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [1:0]        mode = 2'b00;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              a_data = 1'b0;
  logic              b_data = 1'b0;
  logic              busy;
  logic [CNT_W-1:0]  count;
  logic              valid;
`ifdef SET_CNT_CLEAR_EN
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
`endif

  set_count_reader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .rd_en(rd_en), .rd_addr(rd_addr), .a_data(a_data), .b_data(b_data),
    .busy(busy), .count(count), .valid(valid)
`ifdef SET_CNT_CLEAR_EN
    , .clr_we(clr_we), .clr_addr(clr_addr)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Upstream tables: registered read, optional clears; junk on the data lines when not reading.
  logic ta [N];
  logic tbt[N];

  always @(posedge clk) begin
    if (rd_en) begin
      a_data <= ta[rd_addr];
      b_data <= tbt[rd_addr];
    end else begin
      a_data <= 1'($urandom);
      b_data <= 1'($urandom);
    end
`ifdef SET_CNT_CLEAR_EN
    if (clr_we) begin
      ta[clr_addr]  = 1'b0;
      tbt[clr_addr] = 1'b0;
    end
`endif
  end

  task automatic load(input int pat);
    for (int n = 0; n < N; n++) begin
      case (pat)
        0:       begin ta[n] = 1'b1;          tbt[n] = 1'b0;      end
        1:       begin ta[n] = (n % 2 == 0);  tbt[n] = (n < 32);  end
        default: begin ta[n] = 1'b1;          tbt[n] = 1'b1;      end
      endcase
    end
  endtask

  function automatic logic f_hit(input logic [1:0] m, input logic a, input logic b);
    case (m)
      2'b00:   return a;
      2'b01:   return a & b;
      2'b10:   return a | b;
      default: return a ^ b;
    endcase
  endfunction

  // Reference: m_t is the cycle number within a pass (0 = idle); hits snapshotted at start.
  int   m_t   = 0;
  int   m_cnt = 0;
  logic hits[N];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_t   = 0;
      m_cnt = 0;
    end else if (m_t == 0) begin
      if (start) begin
        m_t   = 1;
        m_cnt = 0;
        for (int n = 0; n < N; n++) hits[n] = f_hit(mode, ta[n], tbt[n]);
      end
    end else begin
      if (m_t >= 2 && m_t <= 65) m_cnt += int'(hits[m_t-2]);
      m_t = (m_t == 66) ? 0 : m_t + 1;
    end
  end

  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      check("busy", int'(busy), int'(m_t != 0));
      check("rd_en", int'(rd_en), int'(m_t >= 1 && m_t <= 64));
      if (m_t >= 1 && m_t <= 64) check("rd_addr", int'(rd_addr), m_t - 1);
      check("valid", int'(valid), int'(m_t == 66));
      check("count", int'(count), m_cnt);
`ifdef SET_CNT_CLEAR_EN
      check("clr_we", int'(clr_we), int'(m_t >= 2 && m_t <= 65));
      if (m_t >= 2 && m_t <= 65) check("clr_addr", int'(clr_addr), m_t - 2);
`endif
    end
  end

  task automatic run_pass(input logic [1:0] m, input int exp, input bit perturb);
    int tv, nbusy, nrd, nval, nclr;
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    tv = -1; nbusy = 0; nrd = 0; nval = 0; nclr = 0;
    for (int t = 1; t <= 80; t++) begin
      @(negedge clk);
      start = perturb && (t == 10 || t == 40 || t == 66);
      mode  = (perturb && (t % 2 == 1)) ? ~m : m;
      #1;
      if (busy)  nbusy++;
      if (rd_en) nrd++;
      if (valid) begin
        nval++;
        if (tv < 0) tv = t;
      end
`ifdef SET_CNT_CLEAR_EN
      if (clr_we) nclr++;
`endif
    end
    start = 1'b0;
    mode  = m;
    check("valid_latency", tv, 66);
    check("valid_width", nval, 1);
    check("busy_cycles", nbusy, 66);
    check("rd_en_cycles", nrd, 64);
    check("final_count", int'(count), exp);
`ifdef SET_CNT_CLEAR_EN
    check("clr_we_cycles", nclr, 64);
`endif
  endtask

  initial begin
    load(0);
    #1 rst = 1'b1;
    #3;
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_count", int'(count), 0);
    check("rst_rd_en", int'(rd_en), 0);
    check("rst_rd_addr", int'(rd_addr), 0);
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;

    load(0);
    run_pass(2'b00, 64, 1'b0);
    load(0);
    run_pass(2'b01, 0, 1'b0);
    load(0);
    run_pass(2'b10, 64, 1'b0);
    load(0);
    run_pass(2'b11, 64, 1'b0);

    load(1);
    run_pass(2'b01, 16, 1'b0);
    load(1);
    run_pass(2'b10, 48, 1'b0);
    load(1);
    run_pass(2'b11, 32, 1'b0);
    load(1);
    run_pass(2'b00, 32, 1'b0);

    // Start pulses and mode toggles mid-pass and in DONE must be ignored.
    load(1);
    run_pass(2'b01, 16, 1'b1);
    repeat (5) @(negedge clk);
    #1 check("count_held", int'(count), 16);

    // Abort a pass with reset at cycle 30.
    load(2);
    @(negedge clk);
    start = 1'b1;
    mode  = 2'b01;
    for (int t = 1; t <= 30; t++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_valid", int'(valid), 0);
    check("abort_count", int'(count), 0);
    check("abort_rd_en", int'(rd_en), 0);
    @(negedge clk);
    rst = 1'b0;
    load(2);
    run_pass(2'b01, 64, 1'b0);

`ifdef SET_CNT_CLEAR_EN
    load(2);
    run_pass(2'b10, 64, 1'b0);
    run_pass(2'b00, 0, 1'b0);
    run_pass(2'b01, 0, 1'b0);
    run_pass(2'b10, 0, 1'b0);
    run_pass(2'b11, 0, 1'b0);
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
